// File: rtl/if_bus_bridge_pkg.sv
// Shared types and constants for the instruction-fetch bus bridge.
package if_bus_bridge_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] ZERO_ADDR = '0;

  // Stall request levels driven towards ctrl
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bus-side FSM: IDLE waits for a miss, WAIT holds the request until ack
  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_WAIT = 1'b1
  } if_state_e;

  // One-entry tagged fetch buffer
  typedef struct packed {
    logic                   vld;
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_W-1:0]      data;
  } fetch_buf_t;

  // Instructions are word aligned; the two low PC bits must be zero
  function automatic logic word_aligned(input logic [INST_ADDR_W-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_bus_bridge.sv
// Instruction-fetch bridge: serves the PC stage from a one-entry tagged
// buffer and refills it over a variable-latency req/ack bus, stalling the
// pipeline on a miss until the word arrives.
module if_bus_bridge
  import if_bus_bridge_pkg::*;
#(
  parameter bit BUF_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [INST_ADDR_W-1:0] addr_i,
  input  logic                   flush_i,
  output logic [INST_W-1:0]      inst_o,
  output logic                   stallreq_o,
  output logic                   misalign_o,
  output logic                   bus_req_o,
  output logic [INST_ADDR_W-1:0] bus_addr_o,
  input  logic                   bus_ack_i,
  input  logic [INST_W-1:0]      bus_rdata_i
);

  if_state_e              state_q;
  logic                   bus_req_q;
  logic [INST_ADDR_W-1:0] bus_addr_q;
  fetch_buf_t             buf_q;
  fetch_buf_t             buf_d;

  logic aligned;
  logic hit;
  logic fetch_miss;
  logic ack_take;

  assign aligned    = word_aligned(addr_i);
  assign hit        = BUF_EN && buf_q.vld && (addr_i == buf_q.addr);
  // Misaligned fetches never reach the bus; they are reported instead
  assign fetch_miss = ce_i && aligned && !hit;
  // An ack only counts while a request is actually outstanding
  assign ack_take   = (state_q == IF_WAIT) && bus_req_q && bus_ack_i;

  assign bus_req_o  = bus_req_q;
  assign bus_addr_o = bus_addr_q;

  // Instruction, stall and misalign outputs; all forced quiet during reset
  always_comb begin
    inst_o     = ZERO_WORD;
    stallreq_o = NO_STOP;
    misalign_o = 1'b0;
    if (!rst && ce_i) begin
      if (!aligned) begin
        misalign_o = 1'b1;
      end else if (hit) begin
        inst_o = buf_q.data;
      end else begin
        stallreq_o = STOP;
      end
    end
  end

  // Buffer refill: returned data is tagged with the requested address, and a
  // flush wins over a coincident ack so stale data never becomes visible
  always_comb begin
    buf_d = buf_q;
    if (flush_i) begin
      buf_d.vld = 1'b0;
    end else if (ack_take) begin
      buf_d.vld  = 1'b1;
      buf_d.addr = bus_addr_q;
      buf_d.data = bus_rdata_i;
    end
  end

  // Fetch buffer storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '{vld: 1'b0, addr: ZERO_ADDR, data: ZERO_WORD};
    end else begin
      buf_q <= buf_d;
    end
  end

  // Bus FSM with registered request; an issued request always runs to its ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      bus_req_q  <= 1'b0;
      bus_addr_q <= ZERO_ADDR;
    end else begin
      unique case (state_q)
        IF_IDLE: begin
          if (fetch_miss) begin
            bus_req_q  <= 1'b1;
            bus_addr_q <= addr_i;
            state_q    <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (ack_take) begin
            bus_req_q <= 1'b0;
            state_q   <= IF_IDLE;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= IF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_bus_bridge.sv
// Self-checking bench for if_bus_bridge: directed scenarios plus a random run
// compared against a transaction-level model of the fetch buffer and bus.
module tb_if_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int errors = 0;
  int checks = 0;

  // Model: pending fetch (m_req/m_baddr) and one buffered word
  logic        m_req, m_vld;
  logic [31:0] m_baddr, m_tag, m_data;
  logic [31:0] exp_inst, exp_baddr;
  logic        exp_stall, exp_mis, exp_req;
  int          req_age;

  if_bus_bridge #(.BUF_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .flush_i(flush_i),
    .inst_o(inst_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h3401_1100;
  endfunction

  task automatic model_reset();
    m_req = 1'b0; m_vld = 1'b0; m_baddr = '0; m_tag = '0; m_data = '0;
    req_age = 0;
  endtask

  // Drive one cycle of inputs at the falling edge; the bus responder acks
  // after ws wait states (ws<0: never), and may ack spuriously when idle.
  task automatic drive(input logic ce, input logic [31:0] addr, input logic flush,
                       input int ws, input logic spur, input logic flush_on_ack);
    logic ack;
    @(negedge clk);
    ce_i   = ce;
    addr_i = addr;
    if (bus_req_o) ack = (ws >= 0) && (req_age >= ws);
    else           ack = spur;
    bus_ack_i   = ack;
    bus_rdata_i = bus_req_o ? mem(bus_addr_o) : $urandom;
    flush_i     = flush | (flush_on_ack & ack & bus_req_o);
    #1;
    exp_req   = m_req;
    exp_baddr = m_baddr;
    exp_inst  = '0;
    exp_stall = 1'b0;
    exp_mis   = 1'b0;
    if (!rst && ce) begin
      if (addr[1:0] != 2'b00) exp_mis = 1'b1;
      else if (m_vld && addr == m_tag) exp_inst = m_data;
      else exp_stall = 1'b1;
    end
  endtask

  // Advance the model across the next rising edge
  task automatic tick();
    logic        n_req, n_vld;
    logic [31:0] n_baddr, n_tag, n_data;
    n_req = m_req; n_vld = m_vld; n_baddr = m_baddr; n_tag = m_tag; n_data = m_data;
    if (flush_i) n_vld = 1'b0;
    if (m_req) begin
      if (bus_ack_i) begin
        n_req = 1'b0;
        if (!flush_i) begin
          n_vld = 1'b1; n_tag = m_baddr; n_data = bus_rdata_i;
        end
      end
    end else if (ce_i && addr_i[1:0] == 2'b00 && !(m_vld && addr_i == m_tag)) begin
      n_req = 1'b1; n_baddr = addr_i;
    end
    if (bus_req_o && !bus_ack_i) req_age++;
    else req_age = 0;
    @(posedge clk);
    m_req = n_req; m_vld = n_vld; m_baddr = n_baddr; m_tag = n_tag; m_data = n_data;
  endtask

  task automatic test_reset();
    model_reset();
    ce_i = 1'b1; addr_i = 32'h0000_0006;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%0b want=0", misalign_o); end
    addr_i = 32'h0;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || inst_o !== 32'h0) begin
      errors++; $display("FAIL reset_comb stall=%0b inst=%h want 0/0", stallreq_o, inst_o);
    end
    checks++;
    if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_bus req=%0b addr=%h want 0/0", bus_req_o, bus_addr_o);
    end
    ce_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int nreq = 0, nstall = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
      nreq += bus_req_o; nstall += stallreq_o;
      checks++;
      if (inst_o !== exp_inst) begin errors++; $display("FAIL cold_inst cyc=%0d got=%h want=%h", i, inst_o, exp_inst); end
      tick();
    end
    checks++;
    if (nreq != 1) begin errors++; $display("FAIL cold_req_cycles got=%0d want=1", nreq); end
    checks++;
    if (nstall != 2) begin errors++; $display("FAIL cold_stall_cycles got=%0d want=2", nstall); end
    drive(1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (inst_o !== 32'h3401_1100) begin errors++; $display("FAIL cold_data got=%h want=34011100", inst_o); end
    tick();
  endtask

  task automatic test_hit();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0, 1'b0, 0, 1'b1, 1'b0);
      checks++;
      if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || inst_o !== 32'h3401_1100) begin
        errors++;
        $display("FAIL hit cyc=%0d req=%0b stall=%0b inst=%h want 0/0/34011100", i, bus_req_o, stallreq_o, inst_o);
      end
      tick();
    end
  endtask

  task automatic test_wait_states();
    int nreq = 0, nstall = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h4, 1'b0, 3, 1'b0, 1'b0);
      nstall += stallreq_o;
      if (bus_req_o) begin
        nreq++;
        checks++;
        if (bus_addr_o !== 32'h4) begin errors++; $display("FAIL ws_addr cyc=%0d got=%h want=4", i, bus_addr_o); end
      end
      tick();
    end
    checks++;
    if (nreq != 4) begin errors++; $display("FAIL ws_req_cycles got=%0d want=4", nreq); end
    checks++;
    if (nstall != 5) begin errors++; $display("FAIL ws_stall_cycles got=%0d want=5", nstall); end
    drive(1'b1, 32'h4, 1'b0, 3, 1'b0, 1'b0);
    checks++;
    if (inst_o !== mem(32'h4)) begin errors++; $display("FAIL ws_data got=%h want=%h", inst_o, mem(32'h4)); end
    tick();
  endtask

  task automatic test_addr_change();
    int  rises = 0;
    logic prev = 1'b0, saw20 = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h4, 1'b0, 2, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h20, 1'b0, 2, 1'b0, 1'b0);
      if (bus_req_o && !prev) rises++;
      if (bus_req_o && bus_addr_o == 32'h20) saw20 = 1'b1;
      prev = bus_req_o;
      checks++;
      if (inst_o !== exp_inst || stallreq_o !== exp_stall) begin
        errors++;
        $display("FAIL chg_out cyc=%0d inst=%h stall=%0b want %h/%0b", i, inst_o, stallreq_o, exp_inst, exp_stall);
      end
      tick();
    end
    checks++;
    if (rises != 2 || !saw20) begin errors++; $display("FAIL chg_requests got=%0d saw20=%0b want 2/1", rises, saw20); end
    drive(1'b1, 32'h20, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (inst_o !== mem(32'h20)) begin errors++; $display("FAIL chg_data got=%h want=%h", inst_o, mem(32'h20)); end
    tick();
  endtask

  task automatic test_flush_ack();
    int  rises = 0, nacks = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40, 1'b0, 1, 1'b0, nacks == 0);
      if (bus_req_o && !prev) rises++;
      if (bus_req_o && bus_ack_i) nacks++;
      prev = bus_req_o;
      checks++;
      if (inst_o !== exp_inst || stallreq_o !== exp_stall) begin
        errors++;
        $display("FAIL flush_out cyc=%0d inst=%h stall=%0b want %h/%0b", i, inst_o, stallreq_o, exp_inst, exp_stall);
      end
      tick();
    end
    checks++;
    if (rises != 2) begin errors++; $display("FAIL flush_refetch got=%0d want=2", rises); end
    drive(1'b1, 32'h40, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (inst_o !== mem(32'h40) || stallreq_o !== 1'b0) begin
      errors++; $display("FAIL flush_data inst=%h stall=%0b want %h/0", inst_o, stallreq_o, mem(32'h40));
    end
    tick();
    drive(1'b1, 32'h6, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (misalign_o !== 1'b1 || stallreq_o !== 1'b0 || inst_o !== 32'h0) begin
      errors++; $display("FAIL misalign mis=%0b stall=%0b inst=%h want 1/0/0", misalign_o, stallreq_o, inst_o);
    end
    tick();
    drive(1'b1, 32'h6, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (bus_req_o !== 1'b0) begin errors++; $display("FAIL misalign_noreq got=%0b want=0", bus_req_o); end
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80, 1'b0, -1, 1'b0, 1'b0);
      tick();
    end
    @(negedge clk);
    addr_i = 32'h6;
    checks++;
    if (bus_req_o !== 1'b1) begin errors++; $display("FAIL arst_pre req=%0b want=1", bus_req_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0) begin
      errors++; $display("FAIL arst_bus req=%0b addr=%h want 0/0", bus_req_o, bus_addr_o);
    end
    checks++;
    if (misalign_o !== 1'b0 || stallreq_o !== 1'b0 || inst_o !== 32'h0) begin
      errors++; $display("FAIL arst_comb mis=%0b stall=%0b inst=%h want 0/0/0", misalign_o, stallreq_o, inst_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h80, 1'b0, -1, 1'b1, 1'b0);
    checks++;
    if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
      errors++; $display("FAIL arst_late_ack stall=%0b req=%0b want 1/0", stallreq_o, bus_req_o);
    end
    tick();
    drive(1'b1, 32'h80, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h80) begin
      errors++; $display("FAIL arst_refetch req=%0b addr=%h want 1/80", bus_req_o, bus_addr_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h20, 32'h40, 32'h6, 32'h21};
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 5) != 0, pool[$urandom % 8], ($urandom % 12) == 0,
            int'($urandom % 4), ($urandom % 4) == 0, 1'b0);
      checks++;
      if (inst_o !== exp_inst || stallreq_o !== exp_stall || misalign_o !== exp_mis ||
          bus_req_o !== exp_req || bus_addr_o !== exp_baddr) begin
        errors++;
        $display("FAIL rand cyc=%0d got inst=%h st=%0b mis=%0b req=%0b ba=%h want %h/%0b/%0b/%0b/%h",
                 i, inst_o, stallreq_o, misalign_o, bus_req_o, bus_addr_o,
                 exp_inst, exp_stall, exp_mis, exp_req, exp_baddr);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_wait_states();
    test_addr_change();
    test_flush_ack();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
